// File: rtl/leaf_stream_packetizer.sv
// -----------------------------------------------------------------------------
// leaf_stream_packetizer
//
// Transmit-side endpoint of the BFT leaf protocol. Wraps each beat of a 32-bit
// ready/valid user stream into a 49-bit BFT packet addressed to one fixed
// destination leaf/port. Flow control is credit based: one credit is spent
// per packet, and freespace-update packets from the receiving leaf_interface
// return credits in blocks of FREESPACE_UPDATE_SIZE.
//
// Packet layout: [48] valid, [47:44] leaf, [43:40] port, [39:33] addr,
//                [32] freespace-update flag, [31:0] payload.
//
// Ports:
//   clk                      clock
//   reset                    synchronous, active-high reset
//   din_user_data   [31:0]   user payload (TDATA)
//   din_user_vld             user valid (TVALID)
//   ack_interface2user       ready to user (TREADY), registered
//   din_leaf_bft2interface   packets from the BFT (carry credit returns)
//   dout_leaf_interface2bft  packets to the BFT, each valid for one cycle
//   credit_err               sticky: credit overflow detected
// -----------------------------------------------------------------------------
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int DST_LEAF              = 0,
  parameter int DST_PORT              = 1,
  parameter int SRC_PORT              = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_user_data,
  input  logic                    din_user_vld,
  output logic                    ack_interface2user,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  output logic                    credit_err
);

  // Credits range 0..2^NUM_ADDR_BITS inclusive, hence one extra bit.
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  // Sums are formed one bit wider still so an overflow past the maximum is
  // visible before saturation.
  localparam logic [CREDIT_BITS:0] MAX_CREDITS = (CREDIT_BITS + 1)'(2 ** NUM_ADDR_BITS);
  localparam logic [CREDIT_BITS:0] FS_INC      = (CREDIT_BITS + 1)'(FREESPACE_UPDATE_SIZE);

  localparam logic [NUM_LEAF_BITS-1:0] DST_LEAF_F = NUM_LEAF_BITS'(DST_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] DST_PORT_F = NUM_PORT_BITS'(DST_PORT);
  localparam logic [NUM_PORT_BITS-1:0] SRC_PORT_F = NUM_PORT_BITS'(SRC_PORT);

  // Field positions inside a packet.
  localparam int FLAG_POS  = PAYLOAD_BITS;
  localparam int PORT_LSB  = PAYLOAD_BITS + 1 + NUM_ADDR_BITS;
  localparam int VALID_POS = PACKET_BITS - 1;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                   state, state_d;
  logic [CREDIT_BITS-1:0]   credits, credits_d;
  logic [NUM_ADDR_BITS-1:0] wr_addr, wr_addr_d;
  logic [PACKET_BITS-1:0]   dout_d;
  logic                     ack_d;
  logic                     credit_err_d;

  logic                     xfer;
  logic                     credit_return;
  logic [CREDIT_BITS:0]     credit_sum;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    state_d      = state;
    credits_d    = credits;
    wr_addr_d    = wr_addr;
    dout_d       = '0;
    ack_d        = 1'b0;
    credit_err_d = credit_err;

    // ack is a pure function of state, so a beat moves whenever the user
    // holds valid during a cycle in which ack is already high.
    xfer = din_user_vld & ack_interface2user;

    // Only freespace updates aimed at our local port carry credits; any other
    // traffic on the return path is ignored.
    credit_return = din_leaf_bft2interface[VALID_POS]
                  & din_leaf_bft2interface[FLAG_POS]
                  & (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == SRC_PORT_F);

    credit_sum = {1'b0, credits}
               - {{CREDIT_BITS{1'b0}}, xfer}
               + (credit_return ? FS_INC : '0);

    // More credits than the receiver buffer can hold means the peer returned
    // space it never had; clamp and flag it rather than wrap.
    if (credit_sum > MAX_CREDITS) begin
      credits_d    = MAX_CREDITS[CREDIT_BITS-1:0];
      credit_err_d = 1'b1;
    end else begin
      credits_d    = credit_sum[CREDIT_BITS-1:0];
    end

    if (xfer) begin
      dout_d    = {1'b1, DST_LEAF_F, DST_PORT_F, wr_addr, 1'b0, din_user_data};
      wr_addr_d = wr_addr + 1'b1;
    end

    case (state)
      RUN:     if (credits_d == '0) state_d = STALL;
      STALL:   if (credits_d != '0) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Registered ready: low in the cycle after the last credit is spent, high
    // in the cycle after a return refills an empty counter.
    ack_d = (state_d == RUN);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= RUN;
      credits                 <= MAX_CREDITS[CREDIT_BITS-1:0];
      wr_addr                 <= '0;
      dout_leaf_interface2bft <= '0;
      ack_interface2user      <= 1'b0;
      credit_err              <= 1'b0;
    end else begin
      state                   <= state_d;
      credits                 <= credits_d;
      wr_addr                 <= wr_addr_d;
      dout_leaf_interface2bft <= dout_d;
      ack_interface2user      <= ack_d;
      credit_err              <= credit_err_d;
    end
  end

endmodule

// File: doc/leaf_stream_packetizer.md
Name: leaf_stream_packetizer

Overview:
Transmit-side endpoint of the BFT leaf protocol. Accepts a 32-bit ready/valid user stream and emits 49-bit BFT packets addressed to one fixed destination leaf and port. Flow control is credit based: credits are returned by freespace-update packets from the receiving leaf_interface. It sits between a user kernel's output stream and the BFT injection port, as the counterpart of the receive path inside leaf_interface.

Parameters:
PACKET_BITS, 49, BFT packet width (fixed layout below)
PAYLOAD_BITS, 32, user data width
NUM_LEAF_BITS, 4, leaf field width
NUM_PORT_BITS, 4, port field width
NUM_ADDR_BITS, 7, receiver buffer address width; initial and maximum credit = 2^NUM_ADDR_BITS
FREESPACE_UPDATE_SIZE, 64, credits returned per freespace-update packet
DST_LEAF, 0, destination leaf number
DST_PORT, 1, destination input port at the destination leaf
SRC_PORT, 1, local port number that freespace updates are addressed to

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
din_user_data  input  32  user payload (TDATA)
din_user_vld  input  1  user valid (TVALID)
ack_interface2user  output  1  ready to user (TREADY)
din_leaf_bft2interface  input  49  packets from BFT (carries credit returns)
dout_leaf_interface2bft  output  49  packets to BFT
credit_err  output  1  sticky: credit overflow detected

Behaviour:
- Packet layout: [48] valid, [47:44] leaf, [43:40] port, [39:33] addr, [32] freespace-update flag, [31:0] payload.
- Reset (synchronous): dout = 0, ack = 0, credits = 2^NUM_ADDR_BITS (128), wr_addr = 0, credit_err = 0, FSM = RUN.
- Credit counter width is NUM_ADDR_BITS+1 bits (8). wr_addr is NUM_ADDR_BITS bits and wraps 127 -> 0.
- ack_interface2user = registered (credits != 0) and not in reset. It depends only on state, not on din_user_vld.
- A beat transfers when din_user_vld & ack are both 1 on a rising edge. On the next cycle, dout = {1, DST_LEAF, DST_PORT, wr_addr, 0, data}; wr_addr increments and credits decrement. Latency is 1 cycle.
- No transfer: dout = 0 (valid bit 0). The BFT applies no backpressure, so every packet is held for exactly 1 cycle.
- Credit return: a din packet with [48]=1, [32]=1 and port field == SRC_PORT adds FREESPACE_UPDATE_SIZE to credits. Any other din packet is ignored.
- Simultaneous send and return in the same cycle: credits_next = credits - 1 + FREESPACE_UPDATE_SIZE.
- Overflow: if credits_next exceeds 2^NUM_ADDR_BITS, credits saturate at 128 and credit_err sets. credit_err clears only on reset.
- FSM states:
  - RUN: credits > 0.
  - STALL: credits == 0; ack = 0 and no packets are emitted.
  - STALL -> RUN: on the cycle after a credit return, ack rises.
  - RUN -> STALL: when the last credit is consumed, ack is 0 in the following cycle.
- A user beat held with din_user_vld=1 while ack=0 must not be lost or duplicated. Data is sampled only on a transfer.
- Reset mid-stream: the in-flight dout packet is dropped (dout = 0 next cycle), and credits and address return to their initial values.

Test Plan:
1. Reset, then 3 beats 0xA0,0xA1,0xA2 back-to-back -> dout on cycles +1..+3 = {1,DST_LEAF,DST_PORT,addr 0/1/2,0,data}; credits 125.
2. Stream 128 beats with no returns -> ack drops after the 128th transfer; the 129th beat is held with no packet emitted; FSM = STALL; wr_addr wrapped to 0.
3. From STALL, inject din = valid, flag=1, port=SRC_PORT -> credits = 64 and ack = 1 next cycle; the held beat is sent with addr 0.
4. Transfer and credit return in the same cycle at credits=10 -> credits = 73; no credit_err.
5. At credits=128, inject a return -> credits stay 128, credit_err = 1 and stays 1 until reset. A return with port != SRC_PORT, or with flag=0, leaves credits unchanged.
6. Assert reset for 1 cycle during a stream at wr_addr=40 -> next cycle dout = 0, ack = 0; after release credits = 128, wr_addr = 0, credit_err = 0.
